led_breath_multi: RTL and testbench

//  Multi-channel breathing-LED driver: next generation of the single-channel 4-bit breath driver.

---
 rtl/led_breath_multi_if.sv | 26 ++
 rtl/led_breath_multi.sv | 174 +++++++++++++++++
 tb/tb_led_breath_multi.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_breath_multi_if.sv
// Bus between the LED mode selector (master) and the multi-channel breathing
// driver (slave): per-channel enables and a shared peak level go in, the PWM
// pins and the per-channel breath-complete pulses come back.
interface led_breath_multi_if #(
    parameter int CH    = 4,
    parameter int PWM_W = 8
);
    logic [CH-1:0]    en;
    logic [PWM_W-1:0] max_level;
    logic [CH-1:0]    led_out;
    logic [CH-1:0]    cycle_done;

    modport master (
        output en,
        output max_level,
        input  led_out,
        input  cycle_done
    );

    modport slave (
        input  en,
        input  max_level,
        output led_out,
        output cycle_done
    );
endinterface

// File: rtl/led_breath_multi.sv
// Multi-channel breathing-LED driver. One shared PWM counter and step
// prescaler; each channel runs its own ramp FSM
// (IDLE -> WAIT -> RISE -> HOLD_HI -> FALL -> HOLD_LO -> RISE ..., with a
// FADEOUT exit whenever its enable drops). Brightness saturates at 0 and at
// the target latched on RISE entry.
// Optional feature: define LED_BREATH_GAMMA_EN for a square-law duty curve;
// the default build drives duty linearly from brightness.
module led_breath_multi #(
    parameter int CH         = 4,
    parameter int PWM_W      = 8,
    parameter int STEP_DIV   = 1024,
    parameter int HOLD_STEPS = 16,
    parameter int STAGGER    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    led_breath_multi_if.slave bus
);

    localparam int PRE_W   = $clog2(STEP_DIV);
    localparam int CNT_MAX = ((CH - 1) * STAGGER > HOLD_STEPS - 1) ?
                             (CH - 1) * STAGGER : HOLD_STEPS - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RISE,
        S_HOLD_HI,
        S_FALL,
        S_HOLD_LO,
        S_FADEOUT
    } state_t;

    logic [PRE_W-1:0] prescaler;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick;

    assign tick = (prescaler == PRE_W'(STEP_DIV - 1));

    // Shared free-running PWM counter and brightness-step prescaler.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(i * STAGGER);
        localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_STEPS - 1);

        state_t           state_q, state_d;
        logic [PWM_W-1:0] bright_q, bright_d;
        logic [PWM_W-1:0] target_q, target_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             drop_q, drop_d;
        logic             done_q, done_d;
        logic             led_q;
        logic [PWM_W-1:0] duty;
        logic             at_floor;

        // A ramp-down step that lands on (or starts at) 0 ends the descent.
        assign at_floor = (bright_q <= PWM_W'(1));

`ifdef LED_BREATH_GAMMA_EN
        logic [2*PWM_W-1:0] square;
        assign square = {{PWM_W{1'b0}}, bright_q} * {{PWM_W{1'b0}}, bright_q};
        assign duty   = square[2*PWM_W-1:PWM_W];
`else
        assign duty = bright_q;
`endif

        // Next-state logic: en-low is remembered every clock, all moves happen on tick.
        always_comb begin
            // NOTE: every output of this block gets a default first, so no path
            // leaves a variable unassigned and no latch is inferred.
            state_d  = state_q;
            bright_d = bright_q;
            target_d = target_q;
            cnt_d    = cnt_q;
            done_d   = 1'b0;
            drop_d   = drop_q | (!bus.en[i] && state_q != S_IDLE && state_q != S_FADEOUT);

            if (tick) begin
                if (state_q == S_IDLE) begin
                    if (bus.en[i]) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else if (state_q == S_FADEOUT || drop_d) begin
                    // WAIT has brightness 0, so it falls straight back to IDLE here.
                    drop_d   = 1'b0;
                    bright_d = at_floor ? '0 : bright_q - 1'b1;
                    state_d  = at_floor ? S_IDLE : S_FADEOUT;
                end else begin
                    case (state_q)
                        S_WAIT: begin
                            if (cnt_q == '0) begin
                                state_d  = S_RISE;
                                target_d = bus.max_level;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                        S_RISE: begin
                            if (bright_q >= target_q) begin
                                state_d = S_HOLD_HI;
                                cnt_d   = HOLD_LOAD;
                            end else begin
                                bright_d = bright_q + 1'b1;
                                if (bright_d == target_q) begin
                                    state_d = S_HOLD_HI;
                                    cnt_d   = HOLD_LOAD;
                                end
                            end
                        end
                        S_HOLD_HI: begin
                            if (cnt_q == '0) state_d = S_FALL;
                            else             cnt_d   = cnt_q - 1'b1;
                        end
                        S_FALL: begin
                            bright_d = at_floor ? '0 : bright_q - 1'b1;
                            if (at_floor) begin
                                state_d = S_HOLD_LO;
                                cnt_d   = HOLD_LOAD;
                            end
                        end
                        S_HOLD_LO: begin
                            if (cnt_q == '0) begin
                                state_d  = S_RISE;
                                target_d = bus.max_level;
                                done_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end

        // Channel state register plus the registered PWM and done outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= S_IDLE;
                bright_q <= '0;
                target_q <= '0;
                cnt_q    <= '0;
                drop_q   <= 1'b0;
                done_q   <= 1'b0;
                led_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                bright_q <= bright_d;
                target_q <= target_d;
                cnt_q    <= cnt_d;
                drop_q   <= drop_d;
                done_q   <= done_d;
                led_q    <= (duty > pwm_cnt);
            end
        end

        assign bus.led_out[i]    = led_q;
        assign bus.cycle_done[i] = done_q;
    end

endmodule

// File: tb/tb_led_breath_multi.sv
// Bench for led_breath_multi: a schedule-based model (each channel replays a
// queue of per-tick brightness values) is compared with the DUT outputs every
// clock, and hand-computed tick distances pin the model's timing.
module tb_led_breath_multi;

    localparam int CH         = 4;
    localparam int PWM_W      = 4;
    localparam int STEP_DIV   = 2;
    localparam int HOLD_STEPS = 2;
    localparam int STAGGER    = 3;
    localparam int PERIOD     = 1 << PWM_W;
    localparam int DONE_FLAG  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led_breath_multi_if #(.CH(CH), .PWM_W(PWM_W)) bus ();

    led_breath_multi #(
        .CH(CH), .PWM_W(PWM_W), .STEP_DIV(STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS), .STAGGER(STAGGER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_b      [CH];
    bit            m_active [CH];
    bit            m_fading [CH];
    bit            m_drop   [CH];
    int            sched    [CH][$];
    int            cyc      = 0;
    int            tick_no  = 0;
    logic [CH-1:0] led_exp  = '0;
    logic [CH-1:0] done_exp = '0;

    function automatic int duty_of(input int b);
`ifdef LED_BREATH_GAMMA_EN
        return (b * b) >> PWM_W;
`else
        return b;
`endif
    endfunction

    // One full breath for target t: rise, hold high, fall, hold low (done on last tick).
    task automatic push_profile(input int c, input int t);
        int n;
        n = (t < 1) ? 1 : t;
        for (int k = 1; k <= n; k++) sched[c].push_back((k < t) ? k : t);
        for (int k = 0; k < HOLD_STEPS; k++) sched[c].push_back(t);
        for (int k = 1; k <= n; k++) sched[c].push_back((t - k > 0) ? t - k : 0);
        for (int k = 1; k < HOLD_STEPS; k++) sched[c].push_back(0);
        sched[c].push_back(DONE_FLAG);
    endtask

    task automatic model_step();
        bit tick;
        bit drop_now;
        int e;
        if (!rst_n) begin
            cyc = 0; tick_no = 0; led_exp = '0; done_exp = '0;
            for (int c = 0; c < CH; c++) begin
                m_b[c] = 0; m_active[c] = 0; m_fading[c] = 0; m_drop[c] = 0;
                sched[c].delete();
            end
            return;
        end
        tick = ((cyc % STEP_DIV) == STEP_DIV - 1);
        if (tick) tick_no++;
        for (int c = 0; c < CH; c++) begin
            led_exp[c]  = (duty_of(m_b[c]) > (cyc % PERIOD));
            done_exp[c] = 1'b0;
            drop_now    = m_drop[c] || (m_active[c] && !m_fading[c] && !bus.en[c]);
            m_drop[c]   = tick ? 1'b0 : drop_now;
            if (tick) begin
                if (!m_active[c]) begin
                    if (bus.en[c]) begin
                        m_active[c] = 1;
                        for (int k = 0; k <= c * STAGGER; k++) sched[c].push_back(0);
                    end
                end else begin
                    if (!m_fading[c] && drop_now) begin
                        m_fading[c] = 1;
                        sched[c].delete();
                        if (m_b[c] == 0) sched[c].push_back(0);
                        for (int v = m_b[c] - 1; v >= 0; v--) sched[c].push_back(v);
                    end
                    e = sched[c].pop_front();
                    m_b[c]      = e % DONE_FLAG;
                    done_exp[c] = (e >= DONE_FLAG);
                    if (sched[c].size() == 0) begin
                        if (m_fading[c]) begin
                            m_active[c] = 0;
                            m_fading[c] = 0;
                        end else begin
                            push_profile(c, int'(bus.max_level));
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // ---------------- compare + observation ----------------
    bit chk_on  = 0;
    int done_t  [CH][$];
    int led_hi0 = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("led_out", 32'(bus.led_out), 32'(led_exp));
            check("cycle_done", 32'(bus.cycle_done), 32'(done_exp));
            for (int c = 0; c < CH; c++)
                if (bus.cycle_done[c]) done_t[c].push_back(tick_no);
            if (bus.led_out[0]) led_hi0++;
        end
    end

    function automatic int done_at(input int c, input int k);
        return (done_t[c].size() > k) ? done_t[c][k] : -1;
    endfunction

    task automatic apply_reset(input logic [CH-1:0] en_val, input logic [PWM_W-1:0] lvl);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.en = en_val;
        bus.max_level = lvl;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_led_out", 32'(bus.led_out), 0);
        check("reset_cycle_done", 32'(bus.cycle_done), 0);
        for (int c = 0; c < CH; c++) done_t[c].delete();
        led_hi0 = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int c, input int n, input int budget, input string name);
        int k = 0;
        while (done_t[c].size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_t[c].size() < n) check(name, done_t[c].size(), n);
    endtask

    task automatic wait_bright(input int c, input int v, input int budget, input string name);
        int k = 0;
        while (m_b[c] != v && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (m_b[c] != v) check(name, m_b[c], v);
    endtask

    task automatic wait_idle(input int c, input int budget, input string name);
        int k = 0;
        while (m_active[c] && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (m_active[c]) check(name, 32'(m_active[c]), 0);
    endtask

    initial begin
        int t0, t1, hi;
        bus.en = '0;
        bus.max_level = '0;

        // Duty curve pins.
        hi = 0;
        for (int p = 0; p < PERIOD; p++) if (duty_of(15) > p) hi++;
`ifdef LED_BREATH_GAMMA_EN
        check("duty_at_b8", duty_of(8), 4);
        check("peak_on_clks", hi, 14);
`else
        check("duty_at_b8", duty_of(8), 8);
        check("peak_on_clks", hi, 15);
`endif

        // Reset with all enables high, then staggered start of four channels.
        apply_reset(4'hF, 4'd15);
        wait_done(3, 2, 400, "stagger_timeout");
        for (int c = 0; c < CH; c++) begin
            check($sformatf("first_done_ch%0d", c), done_at(c, 0), 36 + 3 * c);
            check($sformatf("second_done_ch%0d", c), done_at(c, 1), 70 + 3 * c);
        end

        // Mid-operation reset, then en[0] dropped at brightness 10 during RISE.
        apply_reset(4'b0001, 4'd15);
        wait_bright(0, 10, 200, "reach_b10_timeout");
        bus.en[0] = 1'b0;
        t0 = tick_no;
        repeat (6) @(negedge clk);
        bus.en[0] = 1'b1;
        wait_idle(0, 200, "fade_timeout");
        t1 = tick_no;
        check("fade_ticks", t1 - t0, 10);
        check("fade_no_done", done_t[0].size(), 0);
        wait_done(0, 1, 200, "restart_timeout");
        check("restart_done_ticks", done_at(0, 0) - t1, 36);

        // max_level = 0: dark LED but regular done pulses; then 0 -> 15 -> 5 mid-ramp.
        apply_reset(4'b0001, 4'd0);
        wait_done(0, 3, 300, "dark_timeout");
        check("dark_first_done", done_at(0, 0), 8);
        check("dark_period_a", done_at(0, 1) - done_at(0, 0), 6);
        check("dark_period_b", done_at(0, 2) - done_at(0, 1), 6);
        check("dark_led_on_clks", led_hi0, 0);
        bus.max_level = 4'd15;
        wait_done(0, 4, 300, "relatch_timeout");
        wait_bright(0, 5, 200, "mid_rise_timeout");
        bus.max_level = 4'd5;
        wait_done(0, 6, 300, "peak_change_timeout");
        check("period_old_target", done_at(0, 3) - done_at(0, 2), 6);
        check("period_peak_15", done_at(0, 4) - done_at(0, 3), 34);
        check("period_peak_5", done_at(0, 5) - done_at(0, 4), 14);

        repeat (4) @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
